// File: rtl/ucaspian_step_ctrl.sv
// uCaspian run/time-step controller: accumulates run lengths into a target and sequences next_step.
// Optional stall watchdog enabled by defining UCASPIAN_STEP_WDOG_EN.
module ucaspian_step_ctrl #(
  parameter int TIME_W       = 32,
  parameter int TGT_W        = 8,
  parameter int NUM_UNITS    = 5,
  parameter int BLANK_CYCLES = 2
`ifdef UCASPIAN_STEP_WDOG_EN
  ,
  parameter int WDOG_CYCLES  = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_req,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic                 output_pending,
  input  logic [TGT_W-1:0]     tgt_value,
  input  logic                 tgt_vld,
  output logic                 tgt_rdy,
  output logic                 next_step,
  output logic [TIME_W-1:0]    time_current,
  output logic                 time_remaining,
  output logic                 time_update,
  input  logic                 time_sent,
  output logic                 core_active
`ifdef UCASPIAN_STEP_WDOG_EN
  ,
  output logic                 stall_flag,
  output logic [NUM_UNITS-1:0] stall_units
`endif
);

  typedef enum logic [1:0] {IDLE, STEP, BLANK} state_t;

  localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);

  state_t             state, state_nxt;
  logic [3:0]         blank_cnt, blank_cnt_nxt;
  logic [TIME_W-1:0]  target;
  logic               all_done;
  logic               go;
  logic               soft_rst;

  // Saturating accumulate so time_current can never wrap past the target.
  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] a,
                                               input logic [TGT_W-1:0]  b);
    logic [TIME_W:0] sum;
    sum = {1'b0, a} + {{(TIME_W + 1 - TGT_W){1'b0}}, b};
    sat_add = sum[TIME_W] ? '1 : sum[TIME_W-1:0];
  endfunction

  assign soft_rst       = !reset_n || clear_req;
  assign tgt_rdy        = reset_n && !clear_req;
  assign all_done       = (&unit_done) && !output_pending;
  assign time_remaining = target > time_current;
  assign core_active    = time_remaining || (state != IDLE);

  always_comb begin
    state_nxt     = state;
    blank_cnt_nxt = blank_cnt;
    go            = 1'b0;
    case (state)
      IDLE: begin
        if (time_remaining && all_done && !time_update) begin
          go        = 1'b1;
          state_nxt = STEP;
        end
      end
      STEP: begin
        state_nxt     = BLANK;
        blank_cnt_nxt = 4'd0;
      end
      BLANK: begin
        // Stages may still report stale step_done right after next_step.
        if (blank_cnt == BLANK_LAST) state_nxt = IDLE;
        else                         blank_cnt_nxt = blank_cnt + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state        <= IDLE;
      blank_cnt    <= 4'd0;
      next_step    <= 1'b0;
      time_current <= '0;
      target       <= '0;
      time_update  <= 1'b0;
    end else begin
      state     <= state_nxt;
      blank_cnt <= blank_cnt_nxt;
      next_step <= go;
      if (go) time_current <= time_current + TIME_W'(1);
      // A new publish takes priority over an acknowledge in the same cycle.
      if (go)             time_update <= 1'b1;
      else if (time_sent) time_update <= 1'b0;
      if (tgt_vld) target <= sat_add(target, tgt_value);
    end
  end

`ifdef UCASPIAN_STEP_WDOG_EN
  localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      wdog_cnt    <= '0;
      stall_flag  <= 1'b0;
      stall_units <= '0;
    end else if (state == STEP) begin
      wdog_cnt <= '0;
    end else if (state == IDLE && time_remaining && !all_done && !stall_flag) begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if (wdog_cnt == WDOG_LAST) begin
        stall_flag  <= 1'b1;
        stall_units <= unit_done;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// Self-checking bench for ucaspian_step_ctrl; watchdog section active when UCASPIAN_STEP_WDOG_EN is defined.
module tb_ucaspian_step_ctrl;
  localparam int TW   = 10;
  localparam int NU   = 5;
  localparam int BL   = 2;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_req = 1'b0;
  logic [NU-1:0] unit_done = '1;
  logic          output_pending = 1'b0;
  logic [7:0]    tgt_value = 8'd0;
  logic          tgt_vld = 1'b0;
  logic          tgt_rdy;
  logic          next_step;
  logic [TW-1:0] time_current;
  logic          time_remaining;
  logic          time_update;
  logic          time_sent = 1'b0;
  logic          core_active;
`ifdef UCASPIAN_STEP_WDOG_EN
  logic          stall_flag;
  logic [NU-1:0] stall_units;
`endif

  always #5 clk = ~clk;

  ucaspian_step_ctrl #(
    .TIME_W(TW), .TGT_W(8), .NUM_UNITS(NU), .BLANK_CYCLES(BL)
`ifdef UCASPIAN_STEP_WDOG_EN
    , .WDOG_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .unit_done(unit_done),
    .output_pending(output_pending), .tgt_value(tgt_value), .tgt_vld(tgt_vld),
    .tgt_rdy(tgt_rdy), .next_step(next_step), .time_current(time_current),
    .time_remaining(time_remaining), .time_update(time_update), .time_sent(time_sent),
    .core_active(core_active)
`ifdef UCASPIAN_STEP_WDOG_EN
    , .stall_flag(stall_flag), .stall_units(stall_units)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference state: target, time, outstanding publish, cycle of last step.
  int m_target = 0, m_time = 0, cyc_no = 0, last_step = -100;
  bit m_pend = 0;
  bit ack_en = 0;
  int pulse_cnt = 0;
  int pulse_t [0:7];

  typedef struct {
    logic rn;
    logic clr;
    logic exp_rdy;
  } rdy_vec_t;
  rdy_vec_t rdy_tab [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // One clock: predict from the rules, then compare all visible outputs.
  task automatic cyc();
    bit clr, acc, sent, ad, exp_step, exp_act;
    int val;
    clr  = !reset_n || clear_req;
    acc  = tgt_vld && !clr;
    val  = int'(tgt_value);
    sent = time_sent;
    ad   = (&unit_done) && !output_pending;
    @(posedge clk);
    #1;
    cyc_no++;
    exp_step = !clr && ad && !m_pend && (m_target > m_time) && (cyc_no - 1 - last_step > BL);
    if (clr) begin
      m_target = 0; m_time = 0; m_pend = 0; last_step = -100;
    end else begin
      if (exp_step) begin
        m_time++; m_pend = 1; last_step = cyc_no;
      end else if (sent) begin
        m_pend = 0;
      end
      if (acc) m_target = (m_target + val > TMAX) ? TMAX : m_target + val;
    end
    exp_act = (m_target > m_time) || (cyc_no - last_step <= BL);
    chk("next_step", next_step, exp_step);
    chk("time_current", time_current, m_time);
    chk("time_update", time_update, m_pend);
    chk("time_remaining", time_remaining, m_target > m_time);
    chk("core_active", core_active, exp_act);
    if (next_step === 1'b1) begin
      if (pulse_cnt < 8) pulse_t[pulse_cnt] = int'(time_current);
      pulse_cnt++;
    end
    if (ack_en) time_sent = time_update && !time_sent;
  endtask

  task automatic add_tgt(input int v);
    tgt_value = 8'(v);
    tgt_vld   = 1'b1;
    cyc();
    tgt_vld   = 1'b0;
  endtask

  initial begin
    int pc0;
    rdy_tab[0] = '{1'b0, 1'b0, 1'b0};
    rdy_tab[1] = '{1'b0, 1'b1, 1'b0};
    rdy_tab[2] = '{1'b1, 1'b1, 1'b0};
    rdy_tab[3] = '{1'b1, 1'b0, 1'b1};

    // Reset held two cycles
    cyc(); cyc();
    chk("rst_next_step", next_step, 0);
    chk("rst_time_current", time_current, 0);
    chk("rst_time_remaining", time_remaining, 0);
    chk("rst_time_update", time_update, 0);
    chk("rst_core_active", core_active, 0);
    chk("rst_tgt_rdy", tgt_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      reset_n   = rdy_tab[i].rn;
      clear_req = rdy_tab[i].clr;
      #1;
      chk("tgt_rdy_table", tgt_rdy, rdy_tab[i].exp_rdy);
    end
    cyc();

    // Run 3 with prompt publish acknowledge
    ack_en = 1;
    pulse_cnt = 0;
    add_tgt(3);
    repeat (30) cyc();
    chk("run3_pulses", pulse_cnt, 3);
    for (int i = 0; i < 3; i++) chk("run3_time_at_pulse", pulse_t[i], i + 1);
    chk("run3_remaining", time_remaining, 0);
    chk("run3_active", core_active, 0);

    // Busy stage blocks stepping until it reports done
    pulse_cnt = 0;
    unit_done[2] = 1'b0;
    add_tgt(1);
    repeat (20) cyc();
    chk("busy_no_step", pulse_cnt, 0);
    unit_done[2] = 1'b1;
    cyc();
    chk("busy_step_latency", next_step, 1);
    repeat (10) cyc();

    // Publish stall
    ack_en = 0;
    time_sent = 1'b0;
    pulse_cnt = 0;
    pc0 = int'(time_current);
    add_tgt(2);
    for (int k = 0; k < 10 && pulse_cnt == 0; k++) cyc();
    chk("stall_first_step", pulse_cnt, 1);
    repeat (50) cyc();
    chk("stall_hold_time", time_current, pc0 + 1);
    chk("stall_hold_pulses", pulse_cnt, 1);
    time_sent = 1'b1;
    cyc();
    time_sent = 1'b0;
    for (int k = 0; k < 10 && pulse_cnt == 1; k++) cyc();
    chk("stall_second_step", pulse_cnt, 2);
    chk("stall_second_time", time_current, pc0 + 2);
    ack_en = 1;
    repeat (10) cyc();

    // Saturation of the target
    unit_done[2] = 1'b0;
    tgt_value = 8'd255;
    tgt_vld = 1'b1;
    repeat (5) cyc();
    tgt_vld = 1'b0;
    unit_done[2] = 1'b1;
    for (int k = 0; k < 6000 && time_current != TW'(TMAX); k++) cyc();
    chk("sat_reach_max", time_current, TMAX);
    repeat (5) cyc();
    chk("sat_remaining", time_remaining, 0);
    chk("sat_active", core_active, 0);
    add_tgt(255);
    cyc();
    chk("sat_no_wrap", time_remaining, 0);

    // Clear during BLANK aborts the run
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    chk("clr_time_zero", time_current, 0);
    pc0 = pulse_cnt;
    add_tgt(5);
    for (int k = 0; k < 20 && pulse_cnt == pc0; k++) cyc();
    chk("clr_first_step", pulse_cnt, pc0 + 1);
    cyc();
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    chk("clr_blank_time", time_current, 0);
    chk("clr_blank_active", core_active, 0);
    pc0 = pulse_cnt;
    repeat (20) cyc();
    chk("clr_no_more_steps", pulse_cnt, pc0);

    // Randomized traffic against the reference
    ack_en = 0;
    for (int k = 0; k < 2000; k++) begin
      unit_done      = ($urandom % 4 != 0) ? '1 : NU'($urandom);
      output_pending = ($urandom % 10 == 0);
      tgt_vld        = ($urandom % 8 == 0);
      tgt_value      = 8'($urandom % 4);
      time_sent      = time_update && ($urandom % 3 == 0);
      clear_req      = ($urandom % 400 == 0);
      cyc();
    end
    clear_req = 1'b0;
    tgt_vld = 1'b0;
    unit_done = '1;
    output_pending = 1'b0;
    time_sent = 1'b0;
    ack_en = 1;
    for (int k = 0; k < 3000 && core_active; k++) cyc();
    chk("rand_drain_idle", core_active, 0);

`ifdef UCASPIAN_STEP_WDOG_EN
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    unit_done = 5'b10111;
    add_tgt(1);
    repeat (15) cyc();
    chk("wdog_not_yet", stall_flag, 0);
    cyc();
    chk("wdog_flag", stall_flag, 1);
    chk("wdog_units", stall_units, 5'b10111);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    chk("wdog_clr_flag", stall_flag, 0);
    chk("wdog_clr_units", stall_units, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
